// File: rtl/qspi_framebuffer_writer_pkg.sv
// Shared definitions for the QSPI framebuffer write path: state encoding,
// command opcode, address width and the two-clock nibble phase convention
// that the VGA framebuffer reader uses as well.
package qspi_framebuffer_writer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StCmd,
      StAddr,
      StData,
      StGap
   } wr_state_e;

   localparam logic [7:0]  CMD_WRITE_DEF = 8'h38;
   localparam int unsigned ADDR_W        = 24;
   localparam int unsigned CMD_NIBS      = 2;
   localparam int unsigned ADDR_NIBS     = ADDR_W / 4;

   // Each nibble occupies two clk cycles: A launches dout with sck low,
   // B raises sck so the RAM samples on the rising edge.
   localparam logic PHASE_A = 1'b0;
   localparam logic PHASE_B = 1'b1;

   // Nibble idx of a 24-bit address, idx 0 being the most significant.
   function automatic logic [3:0] addr_nibble(input logic [ADDR_W-1:0] addr,
                                              input logic [2:0]        idx);
      logic [3:0] nib;
      nib = 4'h0;
      case (idx)
         3'd0:    nib = addr[23:20];
         3'd1:    nib = addr[19:16];
         3'd2:    nib = addr[15:12];
         3'd3:    nib = addr[11:8];
         3'd4:    nib = addr[7:4];
         3'd5:    nib = addr[3:0];
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/qspi_framebuffer_writer_pixel_fifo.sv
// Synchronous pixel FIFO with occupancy count. DEPTH must be a power of two so
// the pointers wrap naturally and full is simply the top bit of the count.
module qspi_framebuffer_writer_pixel_fifo #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = count_q[PTR_W];
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/qspi_framebuffer_writer.sv
// Write side of the QSPI framebuffer. Buffers gray pixels from the fractal
// engine and, once the shared bus is granted, emits quad-mode write bursts:
// opcode, 24-bit byte address, then pixel nibbles (even pixel = high nibble).
module qspi_framebuffer_writer
   import qspi_framebuffer_writer_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = 76800,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned FIFO_DEPTH   = 32,
   parameter int unsigned CE_GAP       = 2,
   parameter logic [7:0]  CMD_WRITE    = CMD_WRITE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic [3:0] pix_data,
   input  logic       flush,
   input  logic       reset_ptr,
   output logic       bus_req,
   input  logic       bus_grant,
   output logic       qspi_sck,
   output logic       qspi_ce_n,
   output logic [3:0] qspi_dout,
   output logic [3:0] qspi_oe,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned PTR_W = $clog2(FRAME_PIXELS);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LEN_W = $clog2(BURST_LEN + 1);
   localparam int unsigned NIB_W = $clog2(BURST_LEN + ADDR_NIBS + CE_GAP + 1);

   wr_state_e         state_q, state_d;
   logic [NIB_W-1:0]  nib_q, nib_d;
   logic              phase_q, phase_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  real_q, real_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [3:0]        hold_q, hold_d;
   logic              flush_pend_q, flush_pend_d;
   logic              rptr_pend_q, rptr_pend_d;
   logic              frame_done_q, frame_done_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic [3:0]        fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   logic [31:0]       avail;
   logic [31:0]       room;
   logic [31:0]       take;
   logic [31:0]       adv;
   logic              wrap;
   logic              start;
   logic              nib_is_real;
   logic [3:0]        data_a;
   logic [ADDR_W-1:0] byte_addr;

   assign pix_ready  = ~fifo_full;
   assign fifo_push  = pix_valid & pix_ready;
   assign busy       = (state_q != StIdle) | ~fifo_empty;
   assign bus_req    = state_q inside {StReq, StCmd, StAddr, StData};
   assign frame_done = frame_done_q;

   // Two pixels per byte, so the byte address is the pixel pointer halved.
   assign byte_addr = {{(ADDR_W - PTR_W + 1){1'b0}}, ptr_q[PTR_W-1:1]};

   // Slots beyond the real pixel count are the pad nibble of an odd flush.
   assign nib_is_real = 32'(nib_q) < 32'(real_q);
   assign data_a      = nib_is_real ? fifo_rdata : 4'h0;

   qspi_framebuffer_writer_pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_pixel_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (pix_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         nib_q        <= '0;
         phase_q      <= PHASE_A;
         len_q        <= '0;
         real_q       <= '0;
         ptr_q        <= '0;
         hold_q       <= 4'h0;
         flush_pend_q <= 1'b0;
         rptr_pend_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         nib_q        <= nib_d;
         phase_q      <= phase_d;
         len_q        <= len_d;
         real_q       <= real_d;
         ptr_q        <= ptr_d;
         hold_q       <= hold_d;
         flush_pend_q <= flush_pend_d;
         rptr_pend_q  <= rptr_pend_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Burst sequencing, length selection, pointer advance/wrap and pending requests.
   always_comb begin
      state_d      = state_q;
      nib_d        = nib_q;
      phase_d      = phase_q;
      len_d        = len_q;
      real_d       = real_q;
      ptr_d        = ptr_q;
      hold_d       = hold_q;
      flush_pend_d = flush_pend_q | flush;
      rptr_pend_d  = rptr_pend_q;
      frame_done_d = 1'b0;
      fifo_pop     = 1'b0;

      // Burst length: what is buffered, capped by BURST_LEN and by the frame end.
      avail = 32'(fifo_count);
      room  = FRAME_PIXELS - 32'(ptr_q);
      take  = (avail > BURST_LEN) ? BURST_LEN : avail;
      if (take > room) begin
         take = room;
      end
      start = (avail >= BURST_LEN) || (flush_pend_q && (avail != 32'd0));

      adv  = 32'(ptr_q) + 32'(len_q);
      wrap = (adv >= FRAME_PIXELS);
      if (wrap) begin
         adv = adv - FRAME_PIXELS;
      end

      if ((state_q == StIdle) && (avail == 32'd0)) begin
         flush_pend_d = 1'b0;
      end
      // Once the bus is owned the address is committed; defer pointer resets.
      if (reset_ptr && (state_q inside {StCmd, StAddr, StData, StGap})) begin
         rptr_pend_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (reset_ptr) begin
               ptr_d = '0;
            end
            if (start) begin
               state_d = StReq;
               real_d  = LEN_W'(take);
               len_d   = LEN_W'(take + {31'b0, take[0]});
            end
         end
         StReq: begin
            if (reset_ptr) begin
               ptr_d = '0;
            end
            if (bus_grant) begin
               state_d = StCmd;
               nib_d   = '0;
               phase_d = PHASE_A;
            end
         end
         StCmd: begin
            phase_d = ~phase_q;
            if (phase_q == PHASE_B) begin
               if (32'(nib_q) == CMD_NIBS - 1) begin
                  state_d = StAddr;
                  nib_d   = '0;
               end else begin
                  nib_d = nib_q + 1'b1;
               end
            end
         end
         StAddr: begin
            phase_d = ~phase_q;
            if (phase_q == PHASE_B) begin
               if (32'(nib_q) == ADDR_NIBS - 1) begin
                  state_d = StData;
                  nib_d   = '0;
               end else begin
                  nib_d = nib_q + 1'b1;
               end
            end
         end
         StData: begin
            phase_d = ~phase_q;
            if (phase_q == PHASE_A) begin
               hold_d   = data_a;
               fifo_pop = nib_is_real;
            end else if (32'(nib_q) + 32'd1 == 32'(len_q)) begin
               state_d      = StGap;
               nib_d        = '0;
               ptr_d        = PTR_W'(adv);
               frame_done_d = wrap;
            end else begin
               nib_d = nib_q + 1'b1;
            end
         end
         StGap: begin
            if (32'(nib_q) == CE_GAP - 1) begin
               state_d     = StIdle;
               nib_d       = '0;
               rptr_pend_d = 1'b0;
               if (rptr_pend_q || reset_ptr) begin
                  ptr_d = '0;
               end
            end else begin
               nib_d = nib_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // QSPI pin drive, decoded from the current state and nibble phase.
   always_comb begin
      qspi_ce_n = 1'b1;
      qspi_sck  = 1'b0;
      qspi_dout = 4'h0;
      qspi_oe   = 4'h0;
      unique case (state_q)
         StCmd: begin
            qspi_ce_n = 1'b0;
            qspi_sck  = phase_q;
            qspi_oe   = 4'hF;
            qspi_dout = (nib_q == '0) ? CMD_WRITE[7:4] : CMD_WRITE[3:0];
         end
         StAddr: begin
            qspi_ce_n = 1'b0;
            qspi_sck  = phase_q;
            qspi_oe   = 4'hF;
            qspi_dout = addr_nibble(byte_addr, nib_q[2:0]);
         end
         StData: begin
            qspi_ce_n = 1'b0;
            qspi_sck  = phase_q;
            qspi_oe   = 4'hF;
            qspi_dout = (phase_q == PHASE_A) ? data_a : hold_q;
         end
         default: begin
            qspi_ce_n = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_qspi_framebuffer_writer.sv
// Self-checking bench for qspi_framebuffer_writer. A short frame is used so the
// frame-end clipping and wrap are reachable in a few bursts.
module tb_qspi_framebuffer_writer;

   localparam int unsigned FRAME = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid;
   logic       pix_ready;
   logic [3:0] pix_data;
   logic       flush;
   logic       reset_ptr;
   logic       bus_req;
   logic       bus_grant;
   logic       qspi_sck;
   logic       qspi_ce_n;
   logic [3:0] qspi_dout;
   logic [3:0] qspi_oe;
   logic       busy;
   logic       frame_done;

   always #5 clk = ~clk;

   qspi_framebuffer_writer #(
      .FRAME_PIXELS (FRAME),
      .BURST_LEN    (16),
      .FIFO_DEPTH   (32),
      .CE_GAP       (2),
      .CMD_WRITE    (8'h38)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .flush      (flush),
      .reset_ptr  (reset_ptr),
      .bus_req    (bus_req),
      .bus_grant  (bus_grant),
      .qspi_sck   (qspi_sck),
      .qspi_ce_n  (qspi_ce_n),
      .qspi_dout  (qspi_dout),
      .qspi_oe    (qspi_oe),
      .busy       (busy),
      .frame_done (frame_done)
   );

   typedef struct {
      bit         rst_ptr;
      int         npix;
      logic [3:0] base;
      bit         do_flush;
      int         exp_len;
      int         exp_addr;
      int         exp_wrap;
   } vec_t;

   vec_t       vecs [7];
   int         total = 0;
   int         bad   = 0;
   int         fd_cnt = 0;
   int         fd0;
   int         lowcnt;
   logic [3:0] cap_nibs [$];
   int         cap_cycles;
   int         cap_ok;
   int         cap_oe_bad;

   // Count every cycle frame_done is seen high.
   always @(negedge clk) begin
      if (rst_n && frame_done) fd_cnt <= fd_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // All tasks below start and end just after a falling edge.
   task automatic push_pix(input logic [3:0] v);
      int t = 0;
      pix_valid = 1'b1;
      pix_data  = v;
      while (!pix_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      pix_valid = 1'b0;
      if (t >= 5000) chk("push timeout", int'(pix_ready), 1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic pulse_reset_ptr();
      reset_ptr = 1'b1;
      @(negedge clk);
      reset_ptr = 1'b0;
   endtask

   task automatic wait_ce_low();
      int t = 0;
      while (qspi_ce_n && t < 2000) begin
         @(negedge clk);
         t++;
      end
   endtask

   // Record one burst: every ce_n-low cycle, and dout on each sck-high cycle.
   task automatic capture_burst();
      cap_nibs.delete();
      cap_cycles = 0;
      cap_oe_bad = 0;
      wait_ce_low();
      cap_ok = int'(!qspi_ce_n);
      while (!qspi_ce_n && cap_cycles < 200) begin
         cap_cycles++;
         if (qspi_oe != 4'hF) cap_oe_bad++;
         if (qspi_sck) cap_nibs.push_back(qspi_dout);
         @(negedge clk);
      end
   endtask

   task automatic check_burst(input string tag, input int len, input int n,
                              input logic [3:0] base, input int addr);
      int         a;
      int         dbad;
      logic [3:0] e;
      chk({tag, " started"}, cap_ok, 1);
      chk({tag, " ce_n low clks"}, cap_cycles, 16 + 2 * len);
      chk({tag, " oe during burst"}, cap_oe_bad, 0);
      chk({tag, " nibble count"}, cap_nibs.size(), 8 + len);
      if (cap_nibs.size() == 8 + len) begin
         chk({tag, " cmd hi"}, int'(cap_nibs[0]), 3);
         chk({tag, " cmd lo"}, int'(cap_nibs[1]), 8);
         a = 0;
         for (int k = 2; k < 8; k++) a = (a << 4) | int'(cap_nibs[k]);
         chk({tag, " addr"}, a, addr);
         dbad = 0;
         for (int k = 0; k < len; k++) begin
            e = (k < n) ? base + 4'(k) : 4'h0;
            if (cap_nibs[8 + k] != e) dbad++;
         end
         chk({tag, " data nibbles wrong"}, dbad, 0);
      end
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " busy after burst"}, int'(busy), 0);
   endtask

   task automatic pulse_reset_ptr_in_data();
      wait_ce_low();
      repeat (20) @(negedge clk);
      pulse_reset_ptr();
   endtask

   initial begin
      pix_valid = 1'b0;
      pix_data  = 4'h0;
      flush     = 1'b0;
      reset_ptr = 1'b0;
      bus_grant = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset pix_ready", int'(pix_ready), 1);
      chk("reset bus_req", int'(bus_req), 0);
      chk("reset ce_n", int'(qspi_ce_n), 1);
      chk("reset sck", int'(qspi_sck), 0);
      chk("reset dout", int'(qspi_dout), 0);
      chk("reset oe", int'(qspi_oe), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset frame_done", int'(frame_done), 0);

      // {rst_ptr, npix, base, flush, burst len, byte addr, frame wraps}
      vecs[0] = '{1'b0, 16, 4'h0, 1'b0, 16, 0, 0};
      vecs[1] = '{1'b1, 3, 4'hA, 1'b1, 4, 0, 0};
      vecs[2] = '{1'b0, 5, 4'h3, 1'b1, 6, 2, 0};
      vecs[3] = '{1'b0, 16, 4'h7, 1'b0, 16, 5, 0};
      vecs[4] = '{1'b0, 14, 4'h9, 1'b1, 14, 13, 1};
      vecs[5] = '{1'b0, 2, 4'hE, 1'b1, 2, 0, 0};
      vecs[6] = '{1'b1, 1, 4'hF, 1'b1, 2, 0, 0};

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].rst_ptr) pulse_reset_ptr();
         fd0 = fd_cnt;
         for (int k = 0; k < vecs[i].npix; k++) push_pix(vecs[i].base + 4'(k));
         if (vecs[i].do_flush) pulse_flush();
         capture_burst();
         check_burst($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].npix, vecs[i].base,
                     vecs[i].exp_addr);
         wait_idle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d frame_done", i), fd_cnt - fd0, vecs[i].exp_wrap);
      end

      // Grant withheld: request stays up, no chip select, FIFO fills.
      bus_grant = 1'b0;
      pulse_reset_ptr();
      for (int k = 0; k < 20; k++) push_pix(4'(k));
      lowcnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (!qspi_ce_n) lowcnt++;
      end
      chk("nogrant ce_n low clks", lowcnt, 0);
      chk("nogrant bus_req", int'(bus_req), 1);
      chk("nogrant ready at 20", int'(pix_ready), 1);
      for (int k = 20; k < 32; k++) push_pix(4'(k));
      chk("nogrant ready at 32", int'(pix_ready), 0);
      bus_grant = 1'b1;
      capture_burst();
      check_burst("grant1", 16, 16, 4'h0, 0);
      capture_burst();
      check_burst("grant2", 16, 16, 4'h0, 8);
      wait_idle("grant2");

      // Pointer now FRAME-8: burst clipped to 8 at the frame end, then wraps.
      fd0 = fd_cnt;
      for (int k = 0; k < 16; k++) push_pix(4'(k));
      capture_burst();
      check_burst("wrap1", 8, 8, 4'h0, (FRAME - 8) / 2);
      repeat (6) @(negedge clk);
      chk("wrap1 frame_done", fd_cnt - fd0, 1);
      chk("wrap1 leftover busy", int'(busy), 1);
      fd0 = fd_cnt;
      pulse_flush();
      capture_burst();
      check_burst("wrap2", 8, 8, 4'h8, 0);
      wait_idle("wrap2");
      chk("wrap2 frame_done", fd_cnt - fd0, 0);

      // reset_ptr during DATA: burst completes at old address, next at 0.
      for (int k = 0; k < 16; k++) push_pix(4'h3 + 4'(k));
      fork
         capture_burst();
         pulse_reset_ptr_in_data();
      join
      check_burst("rptr1", 16, 16, 4'h3, 4);
      wait_idle("rptr1");
      push_pix(4'h5);
      push_pix(4'h6);
      pulse_flush();
      capture_burst();
      check_burst("rptr2", 2, 2, 4'h5, 0);
      wait_idle("rptr2");

      // Reset asserted in the address phase.
      for (int k = 0; k < 16; k++) push_pix(4'(k));
      wait_ce_low();
      repeat (5) @(negedge clk);
      chk("midrst ce_n low before", int'(qspi_ce_n), 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst ce_n", int'(qspi_ce_n), 1);
      chk("midrst oe", int'(qspi_oe), 0);
      chk("midrst sck", int'(qspi_sck), 0);
      chk("midrst bus_req", int'(bus_req), 0);
      chk("midrst pix_ready", int'(pix_ready), 1);
      chk("midrst busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
